// File: rtl/tag_comparator_pkg.sv
// Shared definitions for the DRAM-cache tag lookup path: FSM encoding,
// tag-metadata bit positions and tag-FIFO entry field layout.
package tag_comparator_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_R = 2'd1,
        S_OUT    = 2'd2
    } tc_state_e;

    localparam int VALID_BIT = 63;
    localparam int DIRTY_BIT = 62;
    localparam int CNT_WIDTH = 32;

    // Tag-FIFO entry is {rw, id, addr} with addr in the low bits.
    localparam int FIFO_ADDR_LSB = 0;

    function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int fifo_id_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int fifo_rw_pos(input int addr_w, input int id_w);
        return addr_w + id_w;
    endfunction

endpackage

// File: rtl/tag_comparator_stat_counter.sv
// Wrapping event counter used for the hit and miss statistics.
module tag_stat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    output logic [WIDTH-1:0] count_o
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_o <= '0;
        end else if (inc_en) begin
            count_o <= count_o + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tag_comparator.sv
// Pops tag lookups from the tag FIFO, matches each against its single-beat
// tag-metadata read response and emits one registered hit/miss result.
module tag_comparator
    import tag_comparator_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int ID_WIDTH     = 16,
    parameter int DATA_WIDTH   = 64,
    parameter int OFFSET_WIDTH = 6,
    parameter int INDEX_WIDTH  = 10,
    localparam int TAG_WIDTH   = tag_width(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         tag_fifo_empty_i,
    input  logic [ADDR_WIDTH+ID_WIDTH:0] tag_fifo_data_i,
    output logic                         tag_fifo_rden_o,

    input  logic [ID_WIDTH-1:0]          rid_i,
    input  logic [DATA_WIDTH-1:0]        rdata_i,
    input  logic [1:0]                   rresp_i,
    input  logic                         rlast_i,
    input  logic                         rvalid_i,
    output logic                         rready_o,

    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic                         res_hit_o,
    output logic                         res_wr_o,
    output logic                         res_dirty_o,
    output logic                         res_err_o,
    output logic [ID_WIDTH-1:0]          res_id_o,
    output logic [ADDR_WIDTH-1:0]        res_addr_o,
    output logic [TAG_WIDTH-1:0]         res_victim_tag_o,

    output logic [CNT_WIDTH-1:0]         hit_cnt_o,
    output logic [CNT_WIDTH-1:0]         miss_cnt_o
);

    localparam int RW_POS = fifo_rw_pos(ADDR_WIDTH, ID_WIDTH);
    localparam int ID_LSB = fifo_id_lsb(ADDR_WIDTH);

    tc_state_e state_q, state_d;

    logic                  req_rw;
    logic [ID_WIDTH-1:0]   req_id;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  err_acc;

    logic                  pop;
    logic                  beat;
    logic                  beat_last;
    logic                  beat_err;
    logic                  result_err;
    logic                  result_hit;
    logic [TAG_WIDTH-1:0]  stored_tag;
    logic [TAG_WIDTH-1:0]  req_tag;

    logic                  unused_rdata_bits;
    assign unused_rdata_bits = ^rdata_i[DIRTY_BIT-1:TAG_WIDTH];

    assign rready_o    = (state_q == S_WAIT_R);
    assign res_valid_o = (state_q == S_OUT);

    assign stored_tag = rdata_i[TAG_WIDTH-1:0];
    assign req_tag    = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];

    // A beat is erroneous if it is not the last one, carries a bad response
    // or belongs to a different transaction; errors on any beat of a burst stick.
    assign beat       = rvalid_i & rready_o;
    assign beat_last  = beat & rlast_i;
    assign beat_err   = (rresp_i != 2'b00) | (rid_i != req_id) | ~rlast_i;
    assign result_err = err_acc | beat_err;
    assign result_hit = ~result_err & rdata_i[VALID_BIT] & (stored_tag == req_tag);

    // Pop is gated by reset so upstream never sees a strobe it cannot honour.
    assign tag_fifo_rden_o = pop & rst_n;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!tag_fifo_empty_i) begin
                    pop     = 1'b1;
                    state_d = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (beat_last) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready_i) begin
                    if (!tag_fifo_empty_i) begin
                        pop     = 1'b1;
                        state_d = S_WAIT_R;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request is latched on pop; it stays separate from the result registers so
    // a new pop in S_OUT never disturbs the result being handed off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_rw   <= 1'b0;
            req_id   <= '0;
            req_addr <= '0;
            err_acc  <= 1'b0;
        end else if (pop) begin
            req_rw   <= tag_fifo_data_i[RW_POS];
            req_id   <= tag_fifo_data_i[ID_LSB +: ID_WIDTH];
            req_addr <= tag_fifo_data_i[FIFO_ADDR_LSB +: ADDR_WIDTH];
            err_acc  <= 1'b0;
        end else if (beat && !rlast_i) begin
            err_acc  <= err_acc | beat_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_hit_o        <= 1'b0;
            res_wr_o         <= 1'b0;
            res_dirty_o      <= 1'b0;
            res_err_o        <= 1'b0;
            res_id_o         <= '0;
            res_addr_o       <= '0;
            res_victim_tag_o <= '0;
        end else if (beat_last) begin
            res_hit_o        <= result_hit;
            res_wr_o         <= req_rw;
            res_dirty_o      <= rdata_i[DIRTY_BIT];
            res_err_o        <= result_err;
            res_id_o         <= req_id;
            res_addr_o       <= req_addr;
            res_victim_tag_o <= stored_tag;
        end
    end

    // Error results count as misses.
    tag_stat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_en  (beat_last & result_hit),
        .count_o (hit_cnt_o)
    );

    tag_stat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_en  (beat_last & ~result_hit),
        .count_o (miss_cnt_o)
    );

endmodule

// File: tb/tb_tag_comparator.sv
// Scoreboard bench for tag_comparator: FIFO, R-channel and result-ready
// drivers feed the DUT while a monitor checks results against a reference model.
module tb_tag_comparator;

    localparam int AW = 64;
    localparam int IW = 16;
    localparam int DW = 64;
    localparam int OW = 6;
    localparam int XW = 10;
    localparam int TW = AW - XW - OW;

    typedef struct {
        logic [IW-1:0] rid;
        logic [DW-1:0] rdata;
        logic [1:0]    rresp;
        logic          rlast;
    } beat_t;

    typedef struct {
        logic          hit;
        logic          wr;
        logic          dirty;
        logic          err;
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [TW-1:0] vtag;
        logic [31:0]   hitCnt;
        logic [31:0]   missCnt;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             tag_fifo_empty_i;
    logic [AW+IW:0]   tag_fifo_data_i;
    logic             tag_fifo_rden_o;
    logic [IW-1:0]    rid_i;
    logic [DW-1:0]    rdata_i;
    logic [1:0]       rresp_i;
    logic             rlast_i;
    logic             rvalid_i;
    logic             rready_o;
    logic             res_valid_o;
    logic             res_ready_i;
    logic             res_hit_o;
    logic             res_wr_o;
    logic             res_dirty_o;
    logic             res_err_o;
    logic [IW-1:0]    res_id_o;
    logic [AW-1:0]    res_addr_o;
    logic [TW-1:0]    res_victim_tag_o;
    logic [31:0]      hit_cnt_o;
    logic [31:0]      miss_cnt_o;

    tag_comparator #(
        .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW),
        .OFFSET_WIDTH(OW), .INDEX_WIDTH(XW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tag_fifo_empty_i(tag_fifo_empty_i), .tag_fifo_data_i(tag_fifo_data_i),
        .tag_fifo_rden_o(tag_fifo_rden_o),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_hit_o(res_hit_o), .res_wr_o(res_wr_o), .res_dirty_o(res_dirty_o),
        .res_err_o(res_err_o), .res_id_o(res_id_o), .res_addr_o(res_addr_o),
        .res_victim_tag_o(res_victim_tag_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    logic [AW+IW:0] fifoQ[$];
    logic [AW+IW:0] pendQ[$];
    beat_t          rQ[$];
    exp_t           sbQ[$];
    int             hsCycles[$];

    int          nVectors = 0;
    int          nMiscompares = 0;
    int          cycle = 0;
    int          readyMode = 2;
    int          rGapMode = 1;
    logic [31:0] expHit = 0;
    logic [31:0] expMiss = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic flagTimeout(input string name);
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL %s: timed out waiting (cycle %0d)", name, cycle);
    endtask

    // Queue one request plus its R beats and record what the model predicts.
    task automatic applyStimulus(input logic rw, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] rdataLast, input logic [1:0] rrespLast,
                                 input logic [IW-1:0] ridLast, input int nBeats);
        beat_t b;
        exp_t  e;
        logic [TW-1:0] reqTag;
        pendQ.push_back({rw, id, addr});
        for (int i = 0; i < nBeats - 1; i++) begin
            b.rid = id; b.rdata = {$urandom, $urandom}; b.rresp = 2'b00; b.rlast = 1'b0;
            rQ.push_back(b);
        end
        b.rid = ridLast; b.rdata = rdataLast; b.rresp = rrespLast; b.rlast = 1'b1;
        rQ.push_back(b);
        reqTag  = TW'(addr >> (OW + XW));
        e.err   = (nBeats > 1) || (rrespLast != 2'b00) || (ridLast != id);
        e.hit   = !e.err && rdataLast[63] && (rdataLast[TW-1:0] == reqTag);
        e.wr    = rw;
        e.dirty = rdataLast[62];
        e.id    = id;
        e.addr  = addr;
        e.vtag  = rdataLast[TW-1:0];
        if (e.hit) expHit = expHit + 1; else expMiss = expMiss + 1;
        e.hitCnt  = expHit;
        e.missCnt = expMiss;
        sbQ.push_back(e);
    endtask

    task automatic checkResetState();
        checkOutput("rst_rden",      64'(tag_fifo_rden_o), 64'h0);
        checkOutput("rst_rready",    64'(rready_o), 64'h0);
        checkOutput("rst_res_valid", 64'(res_valid_o), 64'h0);
        checkOutput("rst_hit",       64'(res_hit_o), 64'h0);
        checkOutput("rst_wr",        64'(res_wr_o), 64'h0);
        checkOutput("rst_dirty",     64'(res_dirty_o), 64'h0);
        checkOutput("rst_err",       64'(res_err_o), 64'h0);
        checkOutput("rst_id",        64'(res_id_o), 64'h0);
        checkOutput("rst_addr",      res_addr_o, 64'h0);
        checkOutput("rst_vtag",      64'(res_victim_tag_o), 64'h0);
        checkOutput("rst_hit_cnt",   64'(hit_cnt_o), 64'h0);
        checkOutput("rst_miss_cnt",  64'(miss_cnt_o), 64'h0);
    endtask

    task automatic waitDrained(input int limit);
        int n;
        n = 0;
        while ((sbQ.size() != 0 || rQ.size() != 0 || fifoQ.size() != 0 || pendQ.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) flagTimeout("drain");
        @(negedge clk);
    endtask

    // First-word-fall-through FIFO model: pops follow the DUT strobe.
    logic popNow;
    initial begin
        tag_fifo_empty_i = 1'b1;
        tag_fifo_data_i  = '0;
        forever begin
            @(negedge clk);
            popNow = tag_fifo_rden_o & rst_n;
            if (tag_fifo_rden_o) checkOutput("rden_while_empty", 64'(tag_fifo_empty_i), 64'h0);
            @(posedge clk);
            #1;
            if (popNow && fifoQ.size() > 0) void'(fifoQ.pop_front());
            while (pendQ.size() > 0) fifoQ.push_back(pendQ.pop_front());
            tag_fifo_empty_i = (fifoQ.size() == 0);
            tag_fifo_data_i  = (fifoQ.size() > 0) ? fifoQ[0] : '0;
        end
    end

    // R-channel driver; also checks the result appears one cycle after the last beat.
    logic rActive;
    logic expectValid;
    beat_t curBeat;
    initial begin
        rvalid_i = 1'b0; rid_i = '0; rdata_i = '0; rresp_i = 2'b00; rlast_i = 1'b0;
        rActive = 1'b0; expectValid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rActive) begin
                rvalid_i = 1'b0;
                if (rQ.size() > 0 && (rGapMode == 1 || $urandom_range(0, 2) != 0)) begin
                    curBeat  = rQ.pop_front();
                    rid_i    = curBeat.rid;
                    rdata_i  = curBeat.rdata;
                    rresp_i  = curBeat.rresp;
                    rlast_i  = curBeat.rlast;
                    rvalid_i = 1'b1;
                    rActive  = 1'b1;
                end
            end
            @(negedge clk);
            if (expectValid) begin
                checkOutput("valid_after_last", 64'(res_valid_o), 64'h1);
                expectValid = 1'b0;
            end
            if (rActive && rready_o && rst_n) begin
                rActive = 1'b0;
                if (rlast_i) expectValid = 1'b1;
            end
        end
    end

    initial begin
        res_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       res_ready_i = 1'($urandom_range(0, 1));
                1:       res_ready_i = 1'b0;
                default: res_ready_i = 1'b1;
            endcase
        end
    end

    // Monitor: every presented result is compared with the scoreboard head.
    exp_t ex;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && res_valid_o) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_result", 64'(res_valid_o), 64'h0);
                end else begin
                    ex = sbQ[0];
                    checkOutput("res_hit",   64'(res_hit_o), 64'(ex.hit));
                    checkOutput("res_wr",    64'(res_wr_o), 64'(ex.wr));
                    checkOutput("res_dirty", 64'(res_dirty_o), 64'(ex.dirty));
                    checkOutput("res_err",   64'(res_err_o), 64'(ex.err));
                    checkOutput("res_id",    64'(res_id_o), 64'(ex.id));
                    checkOutput("res_addr",  res_addr_o, ex.addr);
                    checkOutput("res_vtag",  64'(res_victim_tag_o), 64'(ex.vtag));
                    if (res_ready_i) begin
                        checkOutput("hit_cnt",  64'(hit_cnt_o), 64'(ex.hitCnt));
                        checkOutput("miss_cnt", 64'(miss_cnt_o), 64'(ex.missCnt));
                        void'(sbQ.pop_front());
                        hsCycles.push_back(cycle);
                    end
                end
            end
        end
    end

    logic [AW-1:0] rAddr;
    logic [IW-1:0] rId;
    logic [TW-1:0] rTag;
    int            kind;
    int            waitN;
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState();
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed cases");
        applyStimulus(1'b0, 16'h0012, 64'h0000_1234_5678_9A40,
                      {1'b1, 1'b0, 14'h0, 48'h0000_1234_5678}, 2'b00, 16'h0012, 1);
        waitDrained(100);
        applyStimulus(1'b1, 16'h0021, 64'h0000_0000_0001_0000,
                      {1'b1, 1'b1, 14'h0, 48'h0000_0000_ABCD}, 2'b00, 16'h0021, 1);
        waitDrained(100);
        applyStimulus(1'b0, 16'h0030, 64'hDEAD_BEEF_0000_1000,
                      {1'b0, 1'b0, 14'h0, 48'hDEAD_BEEF_0000}, 2'b00, 16'h0030, 1);
        applyStimulus(1'b0, 16'h0012, 64'h0000_1234_5678_9A40,
                      {1'b1, 1'b0, 14'h0, 48'h0000_1234_5678}, 2'b00, 16'h0013, 1);
        applyStimulus(1'b0, 16'h0012, 64'h0000_1234_5678_9A40,
                      {1'b1, 1'b0, 14'h0, 48'h0000_1234_5678}, 2'b10, 16'h0012, 1);
        applyStimulus(1'b1, 16'h0044, 64'h0000_1234_5678_9A40,
                      {1'b1, 1'b0, 14'h0, 48'h0000_1234_5678}, 2'b00, 16'h0044, 2);
        waitDrained(200);

        $display("[TB] backpressure and back-to-back");
        readyMode = 1;
        for (int i = 0; i < 3; i++) begin
            rAddr = {$urandom, $urandom};
            applyStimulus(1'(i), 16'(16'h0100 + i), rAddr,
                          {1'b1, 1'b0, 14'h0, TW'(rAddr >> (OW + XW))}, 2'b00, 16'(16'h0100 + i), 1);
        end
        waitN = 0;
        while (!res_valid_o && waitN < 50) begin
            @(negedge clk);
            waitN++;
        end
        if (waitN >= 50) flagTimeout("first_result");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_rden",   64'(tag_fifo_rden_o), 64'h0);
            checkOutput("stall_rready", 64'(rready_o), 64'h0);
            checkOutput("stall_valid",  64'(res_valid_o), 64'h1);
        end
        hsCycles.delete();
        readyMode = 2;
        waitDrained(100);
        checkOutput("b2b_count", 64'(hsCycles.size()), 64'h3);
        if (hsCycles.size() == 3) begin
            for (int i = 0; i < 2; i++)
                checkOutput("b2b_spacing", 64'(hsCycles[i+1] - hsCycles[i]), 64'h2);
        end

        $display("[TB] reset in wait state");
        pendQ.push_back({1'b0, 16'h0055, 64'h0000_0000_0055_0000});
        waitN = 0;
        while (!rready_o && waitN < 20) begin
            @(negedge clk);
            waitN++;
        end
        if (waitN >= 20) flagTimeout("reach_wait_r");
        rst_n = 1'b0;
        fifoQ.delete(); pendQ.delete(); rQ.delete(); sbQ.delete();
        expHit = 0; expMiss = 0;
        @(negedge clk);
        checkResetState();
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 16'h0066, 64'h0000_ABCD_EF01_0000,
                      {1'b1, 1'b0, 14'h0, 48'h0000_ABCD_EF01}, 2'b00, 16'h0066, 1);
        waitDrained(100);

        $display("[TB] randomized traffic");
        readyMode = 0;
        rGapMode  = 0;
        for (int t = 0; t < 60; t++) begin
            rAddr = {$urandom, $urandom};
            rId   = 16'($urandom);
            kind  = $urandom_range(0, 9);
            rTag  = (kind < 6) ? TW'(rAddr >> (OW + XW)) : {16'($urandom), $urandom};
            applyStimulus(1'($urandom_range(0, 1)), rId, rAddr,
                          {1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), 14'($urandom), rTag},
                          (kind == 8) ? 2'($urandom_range(1, 3)) : 2'b00,
                          (kind == 7) ? (rId ^ 16'h0001) : rId,
                          (kind == 9) ? 2 : 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        waitDrained(3000);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/tag_comparator.md
# tag_comparator

Consumer end of the DRAM-cache tag lookup path. Pops {rw, id, addr} entries from the tag FIFO and accepts the matching single-beat tag-metadata read response on the R channel from the memory controller. Compares the stored tag against the request address and emits one registered hit/miss result per request to the downstream cache-control logic. Keeps running hit and miss counters.

## Interface
- ADDR_WIDTH, 64: request address width.
- ID_WIDTH, 16: AXI ID width.
- DATA_WIDTH, 64: tag-metadata read data width.
- OFFSET_WIDTH, 6: line-offset bits.
- INDEX_WIDTH, 10: set-index bits.
- TAG_WIDTH is a localparam: ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH (48).
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- tag_fifo_empty_i  in  1  tag FIFO empty. The FIFO is first-word-fall-through.
- tag_fifo_data_i  in  ADDR_WIDTH+ID_WIDTH+1  head entry: [MSB]=rw (1=write), then id, then addr[ADDR_WIDTH-1:0].
- tag_fifo_rden_o  out  1  pop strobe, one cycle per entry.
- rid_i  in  ID_WIDTH  R-channel ID.
- rdata_i  in  DATA_WIDTH  tag metadata: [63]=valid, [62]=dirty, [TAG_WIDTH-1:0]=stored tag.
- rresp_i  in  2  R-channel response.
- rlast_i  in  1  last beat.
- rvalid_i  in  1  R-channel valid.
- rready_o  out  1  R-channel ready.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result ready.
- res_hit_o  out  1  tag hit.
- res_wr_o  out  1  request was a write.
- res_dirty_o  out  1  stored line dirty (the victim is dirty on a miss).
- res_err_o  out  1  response error.
- res_id_o  out  ID_WIDTH  request ID.
- res_addr_o  out  ADDR_WIDTH  request address.
- res_victim_tag_o  out  TAG_WIDTH  stored tag.
- hit_cnt_o, miss_cnt_o  out  32  result counters.

## Operation
- States: S_IDLE, S_WAIT_R, S_OUT.
- **S_IDLE**
  - rready_o=0 and res_valid_o=0.
  - If !tag_fifo_empty_i: assert tag_fifo_rden_o combinationally in the same cycle, latch the head entry into req_rw/req_id/req_addr, clear err_acc, and go to S_WAIT_R.
- **S_WAIT_R**
  - rready_o=1, decoded from state.
  - Each accepted beat (rvalid_i and rready_o): set err_acc if rresp_i≠0, rid_i≠req_id, or rlast_i=0.
  - Beats with rlast_i=0 are discarded, and the block stays in S_WAIT_R.
  - On an accepted beat with rlast_i=1, register the result and go to S_OUT:
    - err = err_acc | this beat's error conditions.
    - hit = !err & rdata_i[63] & (rdata_i[TAG_WIDTH-1:0] == req_addr[ADDR_WIDTH-1 -: TAG_WIDTH]).
    - dirty = rdata_i[62].
    - victim_tag = rdata_i[TAG_WIDTH-1:0].
    - Copy wr, id and addr from the latched request.
  - On the same edge, increment hit_cnt if hit, otherwise miss_cnt. Error results count as misses.
- **S_OUT**
  - res_valid_o=1. All res_* outputs are held stable until res_ready_i.
  - On the handshake: if !tag_fifo_empty_i, pop and latch the next entry in the same cycle and go directly to S_WAIT_R. Otherwise go to S_IDLE.
- Counters wrap modulo 2^32.
- An R beat arriving in S_IDLE or S_OUT is stalled by rready_o=0. It is never dropped.

## Timing
- Reset values: state S_IDLE; rready_o, res_valid_o, tag_fifo_rden_o, and all res_* outputs 0; both counters 0.
- Pop to result:
  - rden_o is asserted in cycle N.
  - rready_o is high from N+1.
  - A last beat accepted in cycle M gives res_valid_o=1 in M+1.
- Steady-state throughput: one result per 2 cycles when R data is present immediately and res_ready_i=1.
- rden_o never asserts while tag_fifo_empty_i=1, and at most once per request.
- Reset during S_WAIT_R or S_OUT drops the held request and result. Upstream blocks are reset together.

## Structure
- Shared package holds: state encoding, TAG_WIDTH derivation, tag-metadata bit positions (VALID_BIT=63, DIRTY_BIT=62), and the tag-FIFO entry field positions shared with the index extractor.
- Natural sub-module: tag_stat_counter, a 32-bit wrapping counter with increment enable. It is instantiated twice.

## Test plan
- Read hit:
  - Stimulus: FIFO {rw=0, id=0x0012, addr=0x0000_1234_5678_9A40}; R beat rid=0x0012, rdata valid=1, tag=0x0000_1234_5678, rresp=0, rlast=1.
  - Response: hit=1, err=0, res_id=0x0012, hit_cnt=1, res_valid 1 cycle after the beat.
- Write miss, dirty victim:
  - Stimulus: rw=1, addr tag 0x1; rdata valid=1, dirty=1, tag=0xABCD.
  - Response: hit=0, wr=1, dirty=1, victim_tag=0xABCD, miss_cnt=1.
- Invalid line with equal tag:
  - Stimulus: rdata valid=0, tag matching the address.
  - Response: hit=0.
- Error cases:
  - rid=0x0013 against req_id 0x0012 → err=1, hit=0.
  - Separately, rresp=2'b10 → err=1.
  - Separately, a 2-beat response with rlast only on the second beat → err=1, with a single result emitted.
- Backpressure and back-to-back:
  - Stimulus: res_ready_i low for 5 cycles with 3 entries queued.
  - Response: outputs stable, no rden, rready_o=0 during the stall.
  - After release: results arrive at 2-cycle spacing, in FIFO order.
- Reset:
  - Stimulus: rst_n low for 1 cycle while in S_WAIT_R.
  - Response: all outputs 0, counters 0, state S_IDLE, and the next entry is processed normally.
